// File: rtl/ls_exec_unit.sv
// Load/store execution unit: takes one LDUR/STUR from the reservation station,
// performs a single memory access and posts the completion back to the ROB.
// Ports: in_clk/in_rst; in_rs_* issue port with out_rs_ready;
//        out_mem_req/we/addr/wdata with in_mem_ack/in_mem_rdata memory port;
//        out_rob_done/dst_rob_index/value/fault completion port; in_rob_is_mispred flush.
// Latency: start at N, ack at N+1 at the earliest, done at N+2; misaligned done at N+1.
// Backpressure: one op in flight; out_rs_ready is low until the unit is back in IDLE.

package ls_exec_pkg;
  typedef enum logic [2:0] {
    FU_OP_NOP  = 3'd0,
    FU_OP_ADD  = 3'd1,
    FU_OP_SUB  = 3'd2,
    FU_OP_LDUR = 3'd3,
    FU_OP_STUR = 3'd4
  } fu_op_t;
endpackage

module ls_exec_unit
  import ls_exec_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ALIGN_BYTES    = 8,
  parameter int GPR_SIZE       = 64,
  parameter int ROB_IDX_SIZE   = 6
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_rs_start,
  input  fu_op_t                  in_rs_op,
  input  logic [GPR_SIZE-1:0]     in_rs_val_a,
  input  logic [GPR_SIZE-1:0]     in_rs_val_b,
  input  logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index,
  input  logic                    in_rob_is_mispred,
  output logic                    out_rs_ready,
  output logic                    out_mem_req,
  output logic                    out_mem_we,
  output logic [GPR_SIZE-1:0]     out_mem_addr,
  output logic [GPR_SIZE-1:0]     out_mem_wdata,
  input  logic                    in_mem_ack,
  input  logic [GPR_SIZE-1:0]     in_mem_rdata,
  output logic                    out_rob_done,
  output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
  output logic [GPR_SIZE-1:0]     out_rob_value,
  output logic                    out_rob_fault
);

  localparam logic [GPR_SIZE-1:0] ALIGN_MASK = GPR_SIZE'(ALIGN_BYTES - 1);
  // Counter value on the last REQ cycle allowed without an ack.
  localparam logic [7:0]          TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    is_st_q, is_st_d;
  logic [GPR_SIZE-1:0]     addr_q, addr_d;
  logic [GPR_SIZE-1:0]     wdata_q, wdata_d;
  logic [ROB_IDX_SIZE-1:0] tag_q, tag_d;
  logic [GPR_SIZE-1:0]     value_q, value_d;
  logic                    fault_q, fault_d;
  logic [7:0]              cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    is_st_d = is_st_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tag_d   = tag_q;
    value_d = value_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        // Non-memory ops and starts during a flush are silently dropped.
        if (in_rs_start && !in_rob_is_mispred &&
            (in_rs_op == FU_OP_LDUR || in_rs_op == FU_OP_STUR)) begin
          is_st_d = (in_rs_op == FU_OP_STUR);
          addr_d  = in_rs_val_a;
          wdata_d = in_rs_val_b;
          tag_d   = in_rs_dst_rob_index;
          value_d = '0;
          cnt_d   = '0;
          if ((in_rs_val_a & ALIGN_MASK) == '0) begin
            state_d = S_REQ;
            fault_d = 1'b0;
          end else begin
            state_d = S_DONE;
            fault_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        // A flush wins over a coincident ack; the ack is discarded.
        if (in_rob_is_mispred) begin
          state_d = S_IDLE;
        end else if (in_mem_ack) begin
          value_d = is_st_q ? '0 : in_mem_rdata;
          state_d = S_DONE;
        end else if (cnt_q == TMO_LAST) begin
          value_d = '0;
          fault_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= S_IDLE;
      is_st_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
      value_q <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      is_st_q <= is_st_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tag_q   <= tag_d;
      value_q <= value_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ready is masked by reset so it reads 0 while reset is held.
  assign out_rs_ready          = (state_q == S_IDLE) && !in_rst;
  assign out_mem_req           = (state_q == S_REQ);
  assign out_mem_we            = (state_q == S_REQ) && is_st_q;
  assign out_mem_addr          = (state_q == S_REQ) ? addr_q  : '0;
  assign out_mem_wdata         = (state_q == S_REQ) ? wdata_q : '0;
  assign out_rob_done          = (state_q == S_DONE);
  assign out_rob_dst_rob_index = tag_q;
  assign out_rob_value         = value_q;
  assign out_rob_fault         = fault_q;

endmodule

// File: tb/tb_ls_exec_unit.sv
// Self-checking bench for ls_exec_unit: directed scenarios plus randomized
// transactions, with expected completions queued at issue time and checked
// by an independent monitor on every done pulse.

module tb_ls_exec_unit;
  import ls_exec_pkg::*;

  localparam int T  = 8;
  localparam int T4 = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rs_start = 1'b0, start4 = 1'b0;
  fu_op_t      rs_op = FU_OP_NOP;
  logic [63:0] val_a = '0, val_b = '0, rdata = '0;
  logic [5:0]  tag = '0;
  logic        mispred = 1'b0, mem_ack = 1'b0, ack4 = 1'b0;

  logic        rs_ready, mem_req, mem_we, rob_done, rob_fault;
  logic [63:0] mem_addr, mem_wdata, rob_value;
  logic [5:0]  rob_tag;
  logic        rs_ready4, mem_req4, mem_we4, rob_done4, rob_fault4;
  logic [63:0] mem_addr4, mem_wdata4, rob_value4;
  logic [5:0]  rob_tag4;

  always #5 clk = ~clk;

  ls_exec_unit #(.TIMEOUT_CYCLES(T), .ALIGN_BYTES(8), .GPR_SIZE(64), .ROB_IDX_SIZE(6)) u_dut (
    .in_clk(clk), .in_rst(rst), .in_rs_start(rs_start), .in_rs_op(rs_op),
    .in_rs_val_a(val_a), .in_rs_val_b(val_b), .in_rs_dst_rob_index(tag),
    .in_rob_is_mispred(mispred), .out_rs_ready(rs_ready),
    .out_mem_req(mem_req), .out_mem_we(mem_we), .out_mem_addr(mem_addr),
    .out_mem_wdata(mem_wdata), .in_mem_ack(mem_ack), .in_mem_rdata(rdata),
    .out_rob_done(rob_done), .out_rob_dst_rob_index(rob_tag),
    .out_rob_value(rob_value), .out_rob_fault(rob_fault)
  );

  // Short-timeout instance used only for the timeout scenario.
  ls_exec_unit #(.TIMEOUT_CYCLES(T4), .ALIGN_BYTES(8), .GPR_SIZE(64), .ROB_IDX_SIZE(6)) u_dut_t4 (
    .in_clk(clk), .in_rst(rst), .in_rs_start(start4), .in_rs_op(rs_op),
    .in_rs_val_a(val_a), .in_rs_val_b(val_b), .in_rs_dst_rob_index(tag),
    .in_rob_is_mispred(mispred), .out_rs_ready(rs_ready4),
    .out_mem_req(mem_req4), .out_mem_we(mem_we4), .out_mem_addr(mem_addr4),
    .out_mem_wdata(mem_wdata4), .in_mem_ack(ack4), .in_mem_rdata(rdata),
    .out_rob_done(rob_done4), .out_rob_dst_rob_index(rob_tag4),
    .out_rob_value(rob_value4), .out_rob_fault(rob_fault4)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [5:0]  tag;
    logic [63:0] val;
    logic        flt;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  // Monitor: every done pulse must match the oldest queued completion.
  always @(negedge clk) begin
    if (!rst && rob_done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: tag %0d value %0h at cycle %0d, none expected",
                 rob_tag, rob_value, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("done_tag",   64'(rob_tag),   64'(mon_e.tag));
        chk("done_value", rob_value,      mon_e.val);
        chk("done_fault", 64'(rob_fault), 64'(mon_e.flt));
        chk("done_cycle", 64'(cyc),       64'(mon_e.cyc));
      end
    end
  end

  // Issue one op. ack_k / mis_k: REQ cycle index at which ack / mispred is
  // driven (-1 = never). Called right after a falling edge.
  task automatic do_op(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [5:0] t, input int ack_k, input logic [63:0] rd,
                       input int mis_k);
    int   n;
    int   e_cyc;
    int   stop;
    bit   legal, mal, mis_hit;
    exp_t e;
    n = 0;
    while (!rs_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("rs_ready_before_start", 64'(rs_ready), 64'd1);
    legal = (op == FU_OP_LDUR) || (op == FU_OP_STUR);
    mal   = (a % 8) != 0;
    rs_start = 1'b1; rs_op = op; val_a = a; val_b = b; tag = t;
    e_cyc = cyc + 1;  // count after the edge that samples the start
    if (legal) begin
      e.tag = t;
      if (mal) begin
        e.val = '0; e.flt = 1'b1; e.cyc = e_cyc;
        q.push_back(e);
      end else begin
        stop = (ack_k >= 0 && ack_k < T) ? ack_k : T - 1;
        if (!(mis_k >= 0 && mis_k <= stop)) begin
          if (ack_k >= 0 && ack_k < T) begin
            e.val = (op == FU_OP_LDUR) ? rd : 64'd0; e.flt = 1'b0; e.cyc = e_cyc + ack_k + 1;
          end else begin
            e.val = '0; e.flt = 1'b1; e.cyc = e_cyc + T;
          end
          q.push_back(e);
        end
      end
    end
    @(negedge clk);
    rs_start = 1'b0;
    val_a = {$urandom, $urandom};
    val_b = {$urandom, $urandom};
    mis_hit = 1'b0;
    if (!legal || mal) begin
      chk("no_mem_req", 64'(mem_req), 64'd0);
      if (!legal) chk("ready_after_drop", 64'(rs_ready), 64'd1);
    end else begin
      for (int k = 0; k < T; k++) begin
        chk("mem_req",  64'(mem_req), 64'd1);
        chk("mem_we",   64'(mem_we),  64'(op == FU_OP_STUR));
        chk("mem_addr", mem_addr, a);
        if (op == FU_OP_STUR) chk("mem_wdata", mem_wdata, b);
        mem_ack = (k == ack_k);
        rdata   = (k == ack_k) ? rd : {$urandom, $urandom};
        mispred = (k == mis_k);
        if (k == mis_k) mis_hit = 1'b1;
        @(negedge clk);
        if (k == ack_k || k == mis_k) break;
      end
      mem_ack = 1'b0;
      mispred = 1'b0;
      chk("req_dropped", 64'(mem_req), 64'd0);
      if (mis_hit) begin
        chk("ready_after_mispred", 64'(rs_ready), 64'd1);
        // A stray ack in IDLE must not produce a completion.
        mem_ack = 1'b1;
        rdata = {$urandom, $urandom};
        @(negedge clk);
        mem_ack = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1);
  end

  initial begin
    int n;
    int r;
    int ak, mk;
    fu_op_t op;
    logic [63:0] a;

    repeat (2) @(negedge clk);
    chk("reset_rs_ready",  64'(rs_ready),  64'd0);
    chk("reset_mem_req",   64'(mem_req),   64'd0);
    chk("reset_rob_done",  64'(rob_done),  64'd0);
    chk("reset_rs_ready4", 64'(rs_ready4), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(rs_ready), 64'd1);

    do_op(FU_OP_LDUR, 64'h40, 64'h0, 6'd3, 0, 64'hDEAD, -1);   // basic load
    do_op(FU_OP_STUR, 64'h80, 64'h7, 6'd5, 4, 64'h0, -1);      // store, 5 REQ cycles
    do_op(FU_OP_LDUR, 64'h43, 64'h0, 6'd7, -1, 64'h0, -1);     // misaligned
    do_op(FU_OP_LDUR, 64'h100, 64'h0, 6'd2, 3, 64'h55, 1);     // flush during REQ
    do_op(FU_OP_LDUR, 64'h108, 64'h0, 6'd8, 2, 64'h66, 2);     // flush coincident with ack
    do_op(FU_OP_ADD,  64'h40, 64'h0, 6'd4, 0, 64'h0, -1);      // non-memory op dropped
    do_op(FU_OP_STUR, 64'h200, 64'h9, 6'd11, -1, 64'h0, -1);   // timeout on main unit

    // Start coincident with flush is ignored.
    rs_start = 1'b1; rs_op = FU_OP_LDUR; val_a = 64'h40; tag = 6'd1; mispred = 1'b1;
    @(negedge clk);
    rs_start = 1'b0; mispred = 1'b0;
    chk("mispred_start_no_req",   64'(mem_req),  64'd0);
    chk("mispred_start_ready",    64'(rs_ready), 64'd1);

    // Timeout with a 4-cycle limit: exactly 4 request cycles then a faulted done.
    start4 = 1'b1; rs_op = FU_OP_LDUR; val_a = 64'h300; tag = 6'd12;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (mem_req4 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("t4_req_cycles", 64'(n),          64'd4);
    chk("t4_done",       64'(rob_done4),  64'd1);
    chk("t4_fault",      64'(rob_fault4), 64'd1);
    chk("t4_value",      rob_value4,      64'd0);
    chk("t4_tag",        64'(rob_tag4),   64'd12);
    @(negedge clk);

    // Asynchronous reset in the middle of a request.
    rs_start = 1'b1; rs_op = FU_OP_LDUR; val_a = 64'h400; tag = 6'd13;
    @(negedge clk);
    rs_start = 1'b0;
    chk("pre_reset_req", 64'(mem_req), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mem_req",  64'(mem_req),  64'd0);
    chk("async_rst_mem_addr", mem_addr,      64'd0);
    chk("async_rst_ready",    64'(rs_ready), 64'd0);
    chk("async_rst_done",     64'(rob_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_async_rst", 64'(rs_ready), 64'd1);
    do_op(FU_OP_LDUR, 64'h408, 64'h0, 6'd14, 1, 64'hBEEF, -1);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 7);
      if (r == 0)      op = FU_OP_SUB;
      else if (r % 2)  op = FU_OP_LDUR;
      else             op = FU_OP_STUR;
      a = {$urandom, $urandom} & ~64'h7;
      if ($urandom_range(0, 3) == 0) a = a | 64'($urandom_range(1, 7));
      ak = $urandom_range(0, 9);
      if (ak >= T) ak = -1;
      mk = ($urandom_range(0, 6) == 0) ? $urandom_range(0, T - 1) : -1;
      do_op(op, a, {$urandom, $urandom}, 6'($urandom_range(0, 63)), ak,
            {$urandom, $urandom}, mk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
